pipeline_hazard_unit: RTL
=========================

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 Parameter MUL_LATENCY, default 4, legal 2..8: cycles a MUL occupies EX.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_valid  in  1  ID holds a real instruction (0 after a flush or bubble).
REQ-005 id_rs_addr, id_rt_addr  in  5 each  source registers of the ID instruction.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt (includes BEQ/BNE/JR compares).
REQ-007 id_rf_w_ena  in  1  ID instruction writes the register file (ID_RF_W_ena from the decoder).
REQ-008 id_waddr  in  5  destination register, already muxed (rd/rt/31).
REQ-009 id_lw, id_mul, id_jump  in  1 each  ID_LW, ID_MUL, jump from the decoder.
REQ-010 stall_if_id  out  1  hold PC and the IF/ID register this cycle.
REQ-011 bubble_ex  out  1  load an empty slot into ID/EX this cycle.
REQ-012 flush_id  out  1  squash the IF/ID register (wrong-path fetch) at the next edge.
REQ-013 fwd_rs_sel, fwd_rt_sel  out  2 each  00 RF, 01 EX result, 10 MEM result, 11 WB result.
REQ-014 mul_busy  out  1  a MUL is still executing in EX.

Function
REQ-015 Unit SHALL keep a 3-entry scoreboard EX/MEM/WB; each entry: valid, wen, waddr[4:0], is_lw.
REQ-016 Entry "matches" a source iff valid & wen & waddr!=0 & use flag & waddr==source addr; register 0 never matches.
REQ-017 load_use SHALL be id_valid & EX.is_lw & EX matches rs or rt.
REQ-018 mul_hold SHALL be (mul_cnt != 0); mul_busy = mul_hold.
REQ-019 stall_if_id = load_use | mul_hold; bubble_ex = load_use & !mul_hold; all combinational.
REQ-020 flush_id = id_valid & id_jump & !stall_if_id; a jump waiting on a stall SHALL not flush until the stall clears.
REQ-021 Forward select per source: EX match (non-LW) -> 01, else MEM match -> 10, else WB match -> 11, else 00; priority EX > MEM > WB.
REQ-022 An EX-stage LW match SHALL yield 00 for that source (load_use stalls instead).
REQ-023 Select outputs SHALL be computed every cycle, including stall cycles.
REQ-024 When mul_hold: EX entry holds, mul_cnt decrements by 1, MEM <= empty, WB <= old MEM.
REQ-025 Otherwise: WB <= MEM, MEM <= EX, EX <= empty if bubble_ex or !id_valid, else ID fields.
REQ-026 When an ID MUL enters EX (id_valid & id_mul & !stall_if_id), mul_cnt SHALL load MUL_LATENCY-1.
REQ-027 A MUL result SHALL forward from EX (01) on the cycle mul_busy falls.
REQ-028 Back-to-back MUL: the second MUL stalls in ID until the first leaves EX, then issues normally.

Reset
REQ-029 rst=1 at an edge SHALL clear all scoreboard valid bits and mul_cnt, including mid-MUL.
REQ-030 After reset: stall_if_id, bubble_ex, flush_id, mul_busy = 0; fwd selects = 00 (given id_valid=0).

Structure
REQ-031 Shared package: forward-select encodings (FWD_RF/EX/MEM/WB), scoreboard entry typedef, MUL_LATENCY default.
REQ-032 One sub-module SHALL be natural: hazard_fwd_sel, combinational priority match for one source operand, instantiated for rs and rt.
REQ-033 Sequential state limited to 3 scoreboard entries and mul_cnt (3 bits).

Verification
REQ-034 addu $3 then addu $5,$3,$1 -> fwd_rs_sel=01, no stall; a third dependent two slots later -> 10.
REQ-035 lw $4 then addu $5,$4,$4 -> one cycle stall_if_id=1, bubble_ex=1, both selects 00; next cycle both selects 10.
REQ-036 mul $6 (MUL_LATENCY=4) then addu $7,$6,$0 -> mul_busy/stall_if_id high 3 cycles, then fwd_rs_sel=01.
REQ-037 beq taken, no hazard -> flush_id=1 one cycle; beq after lw on same reg -> stall 1 cycle, flush_id only on the following cycle.
REQ-038 addu $0,... then addu reading $0 -> selects 00, no stall; rst asserted during MUL -> next cycle mul_busy=0, scoreboard empty.

Source files
------------

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and encodings for the pipeline hazard unit: forward-select
// codes, the per-stage scoreboard entry and the default MUL latency.
package pipeline_hazard_unit_pkg;

  localparam int MUL_LATENCY_DEF = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic [4:0] waddr;
    logic       is_lw;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  // Register 0 is hardwired, so a write to it never produces a dependency.
  function automatic logic sb_match(input sb_entry_t e, input logic use_src,
                                    input logic [4:0] addr);
    return e.valid & e.wen & (e.waddr != 5'd0) & use_src & (e.waddr == addr);
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_fwd_sel.sv
// Priority forward-source select for one ID source operand against the
// EX/MEM/WB scoreboard entries (EX > MEM > WB).
module hazard_fwd_sel
  import pipeline_hazard_unit_pkg::*;
(
  input  sb_entry_t  i_ex,
  input  sb_entry_t  i_mem,
  input  sb_entry_t  i_wb,
  input  logic       i_use,
  input  logic [4:0] i_addr,
  output logic [1:0] o_sel,
  output logic       o_ex_hit
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit  = sb_match(i_ex,  i_use, i_addr);
  assign w_mem_hit = sb_match(i_mem, i_use, i_addr);
  assign w_wb_hit  = sb_match(i_wb,  i_use, i_addr);
  assign o_ex_hit  = w_ex_hit;

  // A load in EX has no data yet; the load-use stall covers it, so select RF.
  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit) begin
      o_sel = i_ex.is_lw ? FWD_RF : FWD_EX;
    end else if (w_mem_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and forwarding control for a 5-stage pipeline with a
// multi-cycle MUL in EX: stalls, bubbles, jump flushes and forward selects.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_rf_w_ena,
  input  logic [4:0] id_waddr,
  input  logic       id_lw,
  input  logic       id_mul,
  input  logic       id_jump,
  output logic       stall_if_id,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       mul_busy
);

  localparam logic [2:0] MUL_LOAD = 3'(MUL_LATENCY - 1);

  sb_entry_t  r_ex;
  sb_entry_t  r_mem;
  sb_entry_t  r_wb;
  logic [2:0] r_mul_cnt;

  logic       w_rs_ex_hit;
  logic       w_rt_ex_hit;
  logic       w_load_use;
  logic       w_mul_hold;
  logic       w_mul_issue;
  sb_entry_t  w_ex_next;

  hazard_fwd_sel u_fwd_rs (
    .i_ex     (r_ex),
    .i_mem    (r_mem),
    .i_wb     (r_wb),
    .i_use    (id_uses_rs),
    .i_addr   (id_rs_addr),
    .o_sel    (fwd_rs_sel),
    .o_ex_hit (w_rs_ex_hit)
  );

  hazard_fwd_sel u_fwd_rt (
    .i_ex     (r_ex),
    .i_mem    (r_mem),
    .i_wb     (r_wb),
    .i_use    (id_uses_rt),
    .i_addr   (id_rt_addr),
    .o_sel    (fwd_rt_sel),
    .o_ex_hit (w_rt_ex_hit)
  );

  assign w_load_use  = id_valid & r_ex.is_lw & (w_rs_ex_hit | w_rt_ex_hit);
  assign w_mul_hold  = (r_mul_cnt != 3'd0);
  assign mul_busy    = w_mul_hold;
  assign stall_if_id = w_load_use | w_mul_hold;
  assign bubble_ex   = w_load_use & ~w_mul_hold;
  // A stalled jump keeps its slot in ID and flushes once the stall clears.
  assign flush_id    = id_valid & id_jump & ~stall_if_id;
  assign w_mul_issue = id_valid & id_mul & ~stall_if_id;

  always_comb begin
    w_ex_next = SB_EMPTY;
    if (id_valid && !bubble_ex) begin
      w_ex_next.valid = 1'b1;
      w_ex_next.wen   = id_rf_w_ena;
      w_ex_next.waddr = id_waddr;
      w_ex_next.is_lw = id_lw;
    end
  end

  // While a MUL holds EX, nothing new enters MEM; older results drain to WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex      <= SB_EMPTY;
      r_mem     <= SB_EMPTY;
      r_wb      <= SB_EMPTY;
      r_mul_cnt <= 3'd0;
    end else if (w_mul_hold) begin
      r_mul_cnt <= r_mul_cnt - 3'd1;
      r_mem     <= SB_EMPTY;
      r_wb      <= r_mem;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_ex_next;
      if (w_mul_issue) begin
        r_mul_cnt <= MUL_LOAD;
      end
    end
  end

endmodule
